// File: rtl/santim_pkg.sv
// Shared definitions for the sanity timer: FSM encoding, DELQA timeout table,
// and the BDCOK pulse length used by the downstream pulse stage.
package santim_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } santim_state_e;

    localparam int unsigned BDCOK_LIMIT = 10;

    // Timeout in quarter-second units for each select code.
    function automatic logic [15:0] santim_lim(input logic [2:0] sel);
        logic [15:0] lim;
        case (sel)
            3'd0:    lim = 16'd1;
            3'd1:    lim = 16'd4;
            3'd2:    lim = 16'd16;
            3'd3:    lim = 16'd64;
            3'd4:    lim = 16'd240;
            3'd5:    lim = 16'd960;
            3'd6:    lim = 16'd3840;
            default: lim = 16'd15360;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/santim_prescale.sv
// Quarter-second prescaler: counts 0..PRESCALE-1 while enabled, pulses tick_o on the
// last count, and sits at zero whenever disabled or cleared.
module santim_prescale #(
    parameter int unsigned PRESCALE = 625000
) (
    input  logic clock_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [19:0] LAST = 20'(PRESCALE - 1);

    logic [19:0] r_cnt;
    logic        w_last;

    assign w_last = (r_cnt == LAST);
    assign tick_o = en_i & w_last;

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i || !en_i || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

endmodule

// File: rtl/santim_wdt.sv
// Sanity watchdog: host activity restarts a DELQA-table timeout; on expiry gen_o is held
// high for the BDCOK pulse stage. Optional SANTIM_WDT_STAT_EN adds an expiry counter.
module santim_wdt
    import santim_pkg::*;
#(
    parameter int unsigned PRESCALE = 625000,
    parameter int unsigned HOLD_MIN = 16
) (
    input  logic       clock_i,
    input  logic       rst_n_i,
    input  logic       ena_i,
    input  logic [2:0] sel_i,
    input  logic       load_i,
    input  logic       kick_i,
    output logic       gen_o,
    output logic       run_o
`ifdef SANTIM_WDT_STAT_EN
    ,
    output logic [7:0] exp_cnt_o
`endif
);

    // Never let the hold drop below what the pulse stage needs to reach its limit.
    localparam int unsigned HOLD_EFF  = (HOLD_MIN > BDCOK_LIMIT + 1) ? HOLD_MIN : BDCOK_LIMIT + 2;
    localparam int unsigned HOLD_W    = $clog2(HOLD_EFF);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EFF - 1);

    santim_state_e     r_state;
    santim_state_e     w_state_d;
    logic [2:0]        r_sel;
    logic [15:0]       r_qcnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_gen;
    logic              r_run;

    logic        w_tick;
    logic        w_restart;
    logic        w_in_run;
    logic        w_pre_clr;
    logic        w_expire;
    logic        w_hold_sat;
    logic [15:0] w_lim_last;

    assign w_restart  = kick_i | load_i;
    assign w_in_run   = (r_state == StRun);
    assign w_pre_clr  = ~w_in_run | w_restart;
    assign w_lim_last = santim_lim(r_sel) - 16'd1;
    assign w_expire   = w_in_run & w_tick & (r_qcnt == w_lim_last);
    assign w_hold_sat = (r_hold == HOLD_LAST);

    santim_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clock_i (clock_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_in_run),
        .clr_i   (w_pre_clr),
        .tick_o  (w_tick)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (ena_i) w_state_d = StRun;
            end
            StRun: begin
                if (!ena_i)         w_state_d = StIdle;
                else if (w_restart) w_state_d = StRun;
                else if (w_expire)  w_state_d = StExpired;
            end
            StExpired: begin
                if (!ena_i)                       w_state_d = StIdle;
                else if (w_hold_sat && w_restart) w_state_d = StRun;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
            r_gen   <= 1'b0;
            r_run   <= 1'b0;
            r_sel   <= 3'd0;
        end else begin
            r_state <= w_state_d;
            r_gen   <= (w_state_d == StExpired);
            r_run   <= (w_state_d == StRun);
            if (load_i) r_sel <= sel_i;
        end
    end

    // Quarter count and hold count both restart from zero on every entry to their state.
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_qcnt <= '0;
            r_hold <= '0;
        end else begin
            if (w_pre_clr)   r_qcnt <= '0;
            else if (w_tick) r_qcnt <= r_qcnt + 16'd1;

            if (r_state != StExpired) r_hold <= '0;
            else if (!w_hold_sat)     r_hold <= r_hold + 1'b1;
        end
    end

`ifdef SANTIM_WDT_STAT_EN
    logic [7:0] r_exp_cnt;

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_exp_cnt <= '0;
        end else if (w_in_run && (w_state_d == StExpired) && (r_exp_cnt != 8'hff)) begin
            r_exp_cnt <= r_exp_cnt + 8'd1;
        end
    end

    assign exp_cnt_o = r_exp_cnt;
`endif

    assign gen_o = r_gen;
    assign run_o = r_run;

endmodule

// File: tb/tb_santim_wdt.sv
// Bench for santim_wdt: directed and random stimulus checked every cycle against an
// elapsed-time model of the watchdog built from the timeout table.
module tb_santim_wdt;

    localparam int unsigned P = 8;
    localparam int unsigned H = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic       load  = 1'b0;
    logic       kick  = 1'b0;
    logic [2:0] sel   = 3'd0;
    logic       gen;
    logic       run;
`ifdef SANTIM_WDT_STAT_EN
    logic [7:0] exp_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int lim_tab [8] = '{1, 4, 16, 64, 240, 960, 3840, 15360};
    int m_mode;     // 0 idle, 1 run, 2 expired
    int m_elapsed;  // cycles since RUN entry or restart
    int m_hold;     // cycles spent expired
    int m_sel;
    int m_exp;

    santim_wdt #(
        .PRESCALE (P),
        .HOLD_MIN (H)
    ) dut (
        .clock_i   (clk),
        .rst_n_i   (rst_n),
        .ena_i     (ena),
        .sel_i     (sel),
        .load_i    (load),
        .kick_i    (kick),
        .gen_o     (gen),
        .run_o     (run)
`ifdef SANTIM_WDT_STAT_EN
        ,
        .exp_cnt_o (exp_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".gen"}, 8'(gen), 8'(m_mode == 2));
        check({tag, ".run"}, 8'(run), 8'(m_mode == 1));
`ifdef SANTIM_WDT_STAT_EN
        check({tag, ".exp_cnt"}, exp_cnt, 8'(m_exp));
`endif
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_elapsed = 0;
        m_hold    = 0;
        m_sel     = 0;
        m_exp     = 0;
    endtask

    task automatic model_step(input logic e, input logic k, input logic l, input logic [2:0] s);
        int lim;
        lim = lim_tab[m_sel] * int'(P);
        case (m_mode)
            0: begin
                if (e) begin
                    m_mode    = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                if (!e) m_mode = 0;
                else if (k || l) m_elapsed = 0;
                else if (m_elapsed + 1 == lim) begin
                    m_mode = 2;
                    m_hold = 0;
                    if (m_exp < 255) m_exp++;
                end else m_elapsed++;
            end
            default: begin
                if (!e) m_mode = 0;
                else if (m_hold >= int'(H) - 1 && (k || l)) begin
                    m_mode    = 1;
                    m_elapsed = 0;
                end else m_hold++;
            end
        endcase
        if (l) m_sel = int'(s);
    endtask

    function automatic logic [2:0] rnd_sel();
        return 3'($urandom_range(7, 0));
    endfunction

    task automatic step(input string tag, input logic e, input logic k, input logic l,
                        input logic [2:0] s);
        ena  = e;
        kick = k;
        load = l;
        sel  = s;
        @(posedge clk);
        model_step(e, k, l, s);
        #1;
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_outs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // load in IDLE only latches the select
        step("idle_load3", 1'b0, 1'b0, 1'b1, 3'd3);
        step("idle_load0", 1'b0, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 4; i++) step("idle_sel_noise", 1'b0, 1'b0, 1'b0, rnd_sel());

        // sel=0: expiry 8 cycles after RUN entry, gen_o held
        for (int i = 0; i < 30; i++) step("sel0_expire", 1'b1, 1'b0, 1'b0, rnd_sel());

        // sel=1 with periodic kicks: never expires
        step("to_idle", 1'b0, 1'b0, 1'b0, 3'd0);
        step("load_sel1", 1'b0, 1'b0, 1'b1, 3'd1);
        for (int i = 0; i < 200; i++)
            step("kicked", 1'b1, 1'(i % 20 == 19), 1'b0, rnd_sel());

        // early kick ignored, late kick restarts
        for (int i = 0; i < 64 && m_mode != 2; i++) step("to_expire", 1'b1, 1'b0, 1'b0, rnd_sel());
        for (int i = 0; i < 5; i++) step("hold", 1'b1, 1'b0, 1'b0, rnd_sel());
        step("early_kick", 1'b1, 1'b1, 1'b0, rnd_sel());
        for (int i = 0; i < 64 && m_hold < 20; i++) step("hold", 1'b1, 1'b0, 1'b0, rnd_sel());
        step("late_kick", 1'b1, 1'b1, 1'b0, rnd_sel());

        // kick exactly on the expiring cycle
        for (int i = 0; i < 64 && !(m_mode == 1 && m_elapsed == 31); i++)
            step("pre_edge", 1'b1, 1'b0, 1'b0, rnd_sel());
        step("edge_kick", 1'b1, 1'b1, 1'b0, rnd_sel());
        for (int i = 0; i < 40; i++) step("re_expire", 1'b1, 1'b0, 1'b0, rnd_sel());
        step("ena_off_exp", 1'b0, 1'b0, 1'b0, rnd_sel());

        // load sel=2 at cycle 10 of RUN
        step("enter", 1'b1, 1'b0, 1'b0, rnd_sel());
        for (int i = 0; i < 20 && m_elapsed < 10; i++) step("run10", 1'b1, 1'b0, 1'b0, rnd_sel());
        step("load_sel2", 1'b1, 1'b0, 1'b1, 3'd2);
        for (int i = 0; i < 140; i++) step("sel2", 1'b1, 1'b0, 1'b0, rnd_sel());

        // longer table entries
        for (int s = 3; s <= 5; s++) begin
            step("sweep_idle", 1'b0, 1'b0, 1'b0, 3'd0);
            step("sweep_load", 1'b0, 1'b0, 1'b1, 3'(s));
            for (int i = 0; i < lim_tab[s] * int'(P) + 4; i++)
                step("sweep", 1'b1, 1'b0, 1'b0, rnd_sel());
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic e, k, l;
            logic [2:0] s;
            e = ($urandom % 64) != 0;
            k = ($urandom % 24) == 0;
            l = ($urandom % 48) == 0;
            s = l ? 3'($urandom_range(2, 0)) : rnd_sel();
            step("random", e, k, l, s);
        end

        // asynchronous reset while gen_o is high
        step("pre_rst_load", 1'b1, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 40 && m_mode != 2; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, rnd_sel());
        check_outs("pre_rst_expired");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        ena = 1'b0;
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst", 1'b0, 1'b0, 1'b0, rnd_sel());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
